// File: rtl/grf_wport_arbiter.sv
// GRF write-port arbiter: the pipeline W stage wins the port, and an aux FIFO is drained
// in free cycles. A forced one-cycle stall guarantees that the aux FIFO keeps draining.
module grf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        a_we,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_wd,
    output logic        stall_a,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_wd,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    input  logic [4:0]  q_addr,
    output logic        q_pend
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FORCE = 1'b1;

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_wd   [DEPTH];
    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;
    logic [0:0]    state_reg;
    logic [WW-1:0] wait_reg;
    logic [DEPTH-1:0] hit;

    logic a_win, fifo_ne, pop, push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign stall_a = (state_reg == FORCE);
    assign b_ready = (count_reg < CW'(DEPTH)) && !clr;
    assign a_win   = a_we && !stall_a;
    assign fifo_ne = (count_reg != '0);
    assign pop     = !a_win && fifo_ne;
    assign push    = b_valid && b_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[tail_reg] <= b_addr;
            mem_wd[tail_reg]   <= b_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            state_reg <= RUN;
            wait_reg  <= '0;
            grf_we    <= 1'b0;
            grf_a3    <= '0;
            grf_wd    <= '0;
        end else begin
            if (push) tail_reg <= next_ptr(tail_reg);
            if (pop)  head_reg <= next_ptr(head_reg);
            if (push && !pop)      count_reg <= count_reg + CW'(1);
            else if (pop && !push) count_reg <= count_reg - CW'(1);

            // Register 0 writes still consume the grant; only the enable is suppressed.
            if (a_win) begin
                grf_we <= (a_addr != 5'd0);
                grf_a3 <= a_addr;
                grf_wd <= a_wd;
            end else if (pop) begin
                grf_we <= (mem_addr[head_reg] != 5'd0);
                grf_a3 <= mem_addr[head_reg];
                grf_wd <= mem_wd[head_reg];
            end else begin
                grf_we <= 1'b0;
            end

            if (state_reg == FORCE) begin
                state_reg <= RUN;
                wait_reg  <= '0;
            end else if (fifo_ne && !pop) begin
                if (wait_reg == WW'(STARVE_LIMIT - 1)) begin
                    state_reg <= FORCE;
                    wait_reg  <= '0;
                end else begin
                    wait_reg <= wait_reg + WW'(1);
                end
            end else begin
                wait_reg <= '0;
            end
        end
    end

    // A slot is live when its distance from head (mod DEPTH) is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW:0] off_raw, off;
            assign off_raw = (PW+1)'(gi + DEPTH) - {1'b0, head_reg};
            assign off     = (off_raw >= (PW+1)'(DEPTH)) ? off_raw - (PW+1)'(DEPTH) : off_raw;
            assign hit[gi] = (32'(off) < 32'(count_reg)) && (mem_addr[gi] == q_addr);
        end
    endgenerate

    assign q_pend = (q_addr != 5'd0) && (|hit);

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed bench for grf_wport_arbiter: a queue-based reference model is checked every cycle,
// and literal expectations pin the key scenarios.
module tb_grf_wport_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        a_we = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_wd = '0;
    logic        stall_a;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_wd = '0;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [4:0]  q_addr = '0;
    logic        q_pend;

    grf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .clr(clr),
        .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd), .stall_a(stall_a),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_wd(b_wd),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd),
        .q_addr(q_addr), .q_pend(q_pend)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a FIFO queue of pending B writes plus a starvation counter.
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        mq[$];
    bit          m_force = 0;
    int          m_wait = 0;
    logic        e_we = 0;
    logic [4:0]  e_a3 = '0;
    logic [31:0] e_wd = '0;

    always @(posedge clk) begin
        int   n;
        bit   popped;
        ent_t e;
        if (clr) begin
            mq.delete();
            m_force = 0; m_wait = 0;
            e_we = 0; e_a3 = '0; e_wd = '0;
        end else begin
            n = mq.size();
            popped = 0;
            if (a_we && !m_force) begin
                e_we = (a_addr != 0); e_a3 = a_addr; e_wd = a_wd;
            end else if (n > 0) begin
                e = mq.pop_front();
                e_we = (e.a != 0); e_a3 = e.a; e_wd = e.d;
                popped = 1;
            end else begin
                e_we = 0;
            end
            if (m_force) begin
                m_force = 0; m_wait = 0;
            end else if (n > 0 && !popped) begin
                m_wait++;
                if (m_wait >= STARVE_LIMIT) begin m_force = 1; m_wait = 0; end
            end else begin
                m_wait = 0;
            end
            if (b_valid && n < DEPTH) mq.push_back('{b_addr, b_wd});
        end
    end

    always @(negedge clk) begin
        bit pend;
        pend = 0;
        foreach (mq[i]) if (mq[i].a == q_addr && q_addr != 0) pend = 1;
        chk("model_stall_a", {31'b0, stall_a}, {31'b0, m_force});
        chk("model_b_ready", {31'b0, b_ready}, {31'b0, (mq.size() < DEPTH) && !clr});
        chk("model_grf_we", {31'b0, grf_we}, {31'b0, e_we});
        chk("model_q_pend", {31'b0, q_pend}, {31'b0, pend});
        if (e_we) begin
            chk("model_grf_a3", {27'b0, grf_a3}, {27'b0, e_a3});
            chk("model_grf_wd", grf_wd, e_wd);
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    initial begin
        // 1. reset and idle
        tick; tick;
        clr = 1'b0; q_addr = 5'd3;
        at_neg;
        chk("rst_grf_we", {31'b0, grf_we}, 32'd0);
        chk("rst_grf_a3", {27'b0, grf_a3}, 32'd0);
        chk("rst_stall", {31'b0, stall_a}, 32'd0);
        chk("rst_b_ready", {31'b0, b_ready}, 32'd1);
        chk("rst_q_pend", {31'b0, q_pend}, 32'd0);
        q_addr = 5'd0;

        // 2. single A write
        a_we = 1'b1; a_addr = 5'd5; a_wd = 32'h1234;
        tick;
        a_we = 1'b0;
        at_neg;
        chk("a_we", {31'b0, grf_we}, 32'd1);
        chk("a_a3", {27'b0, grf_a3}, 32'd5);
        chk("a_wd", grf_wd, 32'h1234);
        tick; at_neg;
        chk("a_we_off", {31'b0, grf_we}, 32'd0);
        chk("a_a3_hold", {27'b0, grf_a3}, 32'd5);
        chk("a_wd_hold", grf_wd, 32'h1234);

        // 3. two B pushes drain in order
        b_valid = 1'b1; b_addr = 5'd8; b_wd = 32'hAAAA;
        tick;
        b_addr = 5'd9; b_wd = 32'hBBBB;
        tick;
        b_valid = 1'b0;
        at_neg;
        chk("b1_a3", {27'b0, grf_a3}, 32'd8);
        chk("b1_wd", grf_wd, 32'hAAAA);
        tick; at_neg;
        chk("b2_a3", {27'b0, grf_a3}, 32'd9);
        chk("b2_wd", grf_wd, 32'hBBBB);
        tick; at_neg;
        chk("b_idle_we", {31'b0, grf_we}, 32'd0);

        // 4. starvation forces a one-cycle stall
        a_we = 1'b1; a_addr = 5'd1; a_wd = 32'h11;
        b_valid = 1'b1; b_addr = 5'd7; b_wd = 32'h77;
        tick;
        b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_neg;
            chk("starve_wait_stall", {31'b0, stall_a}, 32'd0);
            tick;
        end
        at_neg;
        chk("force_stall", {31'b0, stall_a}, 32'd1);
        tick; at_neg;
        chk("force_we", {31'b0, grf_we}, 32'd1);
        chk("force_a3", {27'b0, grf_a3}, 32'd7);
        chk("force_wd", grf_wd, 32'h77);
        chk("force_release", {31'b0, stall_a}, 32'd0);
        a_we = 1'b0;
        tick;

        // 5. fill FIFO, pending query, then drain with a same-cycle push/pop
        a_we = 1'b1; a_addr = 5'd2; a_wd = 32'h22;
        b_valid = 1'b1; b_addr = 5'd10; b_wd = 32'hA0;
        tick;
        b_addr = 5'd11; b_wd = 32'hB0;
        tick;
        b_addr = 5'd12; b_wd = 32'hC0;
        at_neg;
        chk("full_b_ready", {31'b0, b_ready}, 32'd0);
        #1 q_addr = 5'd10;
        #1 chk("q_pend_head", {31'b0, q_pend}, 32'd1);
        q_addr = 5'd11;
        #1 chk("q_pend_tail", {31'b0, q_pend}, 32'd1);
        q_addr = 5'd0;
        #1 chk("q_pend_r0", {31'b0, q_pend}, 32'd0);
        tick;
        a_we = 1'b0;
        tick; at_neg;
        chk("drain1_a3", {27'b0, grf_a3}, 32'd10);
        chk("drain1_ready", {31'b0, b_ready}, 32'd1);
        tick;
        b_valid = 1'b0;
        at_neg;
        chk("drain2_a3", {27'b0, grf_a3}, 32'd11);
        tick; at_neg;
        chk("drain3_a3", {27'b0, grf_a3}, 32'd12);
        chk("drain3_wd", grf_wd, 32'hC0);
        tick; at_neg;
        chk("drain_idle", {31'b0, grf_we}, 32'd0);

        // 6a. B write to r0 pops without enabling the port
        b_valid = 1'b1; b_addr = 5'd0; b_wd = 32'h55;
        tick;
        b_valid = 1'b0;
        tick; at_neg;
        chk("r0_we", {31'b0, grf_we}, 32'd0);
        chk("r0_popped", {31'b0, b_ready}, 32'd1);

        // 6b. clr while FIFO full and FORCE pending
        a_we = 1'b1; a_addr = 5'd3; a_wd = 32'h33;
        b_valid = 1'b1; b_addr = 5'd13; b_wd = 32'hD0;
        tick;
        b_addr = 5'd14; b_wd = 32'hE0;
        tick;
        b_valid = 1'b0;
        tick; tick; tick;
        at_neg;
        chk("clr_pre_stall", {31'b0, stall_a}, 32'd1);
        chk("clr_pre_full", {31'b0, b_ready}, 32'd0);
        #1 clr = 1'b1;
        tick; at_neg;
        chk("clr_stall", {31'b0, stall_a}, 32'd0);
        chk("clr_we", {31'b0, grf_we}, 32'd0);
        chk("clr_ready_low", {31'b0, b_ready}, 32'd0);
        #1 clr = 1'b0; a_we = 1'b0;
        tick; at_neg;
        #1 q_addr = 5'd13;
        #1 chk("clr_empty_ready", {31'b0, b_ready}, 32'd1);
        chk("clr_q_pend", {31'b0, q_pend}, 32'd0);
        q_addr = 5'd0;
        tick; tick;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
